cordic_req_scheduler: RTL and testbench
=======================================

// Module: cordic_req_scheduler
// PURPOSE
//  Shares one non-stallable pipelined CORDIC cosine core among NREQ requesters.
//  Each cycle it round-robin arbitrates valid/ready requests and issues at most one angle.
//  A tag pipeline tracks the requester ID of every in-flight angle and returns each result
//  to its owner, aligned to the core's latency.
//  A flush FSM stops new issue and reports when the core pipeline is empty.
//  Sits between the core and its client blocks.
// PARAMETERS
//  NREQ        4    number of requesters (2..8)
//  CORDIC_LAT  16   cycles from cordic_angle register update to matching cordic_cos
//  ID_W        $clog2(NREQ)  requester tag width (derived localparam)
// PORTS
//  clock        in   1          single system clock, all logic posedge
//  reset        in   1          synchronous, active-high
//  req_valid    in   NREQ       per-requester request valid
//  req_angle    in   NREQ*32    per-requester signed angle; slice i = [32*i+31:32*i]
//  req_ready    out  NREQ       one-hot grant; handshake = req_valid[i] & req_ready[i]
//  cordic_angle out  32         registered angle driven to the core
//  cordic_cos   in   32         core output, sign-extended cosine
//  resp_valid   out  NREQ       one-hot, asserted for the cycle its result is on resp_data
//  resp_data    out  32         equals cordic_cos (shared by all requesters)
//  resp_id      out  ID_W       owner of the current resp_data
//  flush        in   1          level request to stop issue and drain
//  flush_done   out  1          high while in DONE state
//  busy         out  1          any tag-pipe entry valid
// BEHAVIOUR
//  Reset values: req_ready=0, cordic_angle=0, tag pipe all invalid, resp_valid=0,
//    resp_id=0, rr pointer=0, FSM=RUN, flush_done=0, busy=0.
//  Arbitration (RUN only): grant the first valid index at or after rr_ptr, modulo NREQ.
//  req_ready is combinational from req_valid, rr_ptr and the FSM state. It is one-hot or zero.
//  It never depends on resp.
//  On a handshake at edge t:
//    cordic_angle <= req_angle[i]; tag_pipe[0] <= {1,i}; rr_ptr <= (i+1) mod NREQ.
//  With no grant: cordic_angle <= 0, tag_pipe[0] <= invalid, rr_ptr unchanged.
//  Tag pipe: CORDIC_LAT-deep shift register of {valid,id}. It advances every cycle and never stalls.
//  resp_valid[k] = tail.valid & (tail.id==k); resp_id = tail.id; resp_data = cordic_cos.
//  Result of a handshake at edge t: resp_valid is high in exactly the cycle after edge t+CORDIC_LAT.
//    Throughput is 1 per cycle. Responses come back in issue order and have no backpressure.
//  FSM:
//    RUN   -> DRAIN when flush=1 (no grant in that cycle).
//    DRAIN -> DONE  when busy=0.
//    DONE  -> RUN   when flush=0.
//    DONE holds while flush=1. In DRAIN and DONE, req_ready=0.
//  Boundaries:
//    All NREQ valid continuously: each granted once per NREQ cycles, with no starvation.
//    flush and a request in the same cycle: flush wins, no grant.
//    flush when the pipe is empty: DRAIN for one cycle, then DONE.
//    Reset mid-flight: all tags dropped and no resp_valid afterwards. Stale core data is ignored.
//    rr_ptr wraps NREQ-1 -> 0.
// CONFIGURATION
//  CORDIC_SCHED_STATS_EN defined: adds output issue_cnt (NREQ*16).
//    It holds one 16-bit per-requester counter, +1 on each handshake.
//    Counters saturate at 16'hFFFF and clear on reset.
//  Undefined: no issue_cnt port and no counters. All other behaviour is identical.
// STRUCTURE
//  Shared package cordic_pkg: CORDIC_LAT default, angle/result width (32),
//    tag typedef {valid, id}, FSM state enum (RUN, DRAIN, DONE).
//  Sub-module cordic_tag_pipe (DEPTH, ID_W): the tag shift register plus busy (OR of valids).
//  Arbiter and FSM stay in this module.
// TESTING
//  Golden model: a standalone core instance fed the same angle sequence.
//  1. Single req0, angle 32'h0 at edge t -> resp_valid=4'b0001, resp_id=0 at t+16,
//     resp_data matches golden; no other resp_valid.
//  2. All 4 valid, 12 cycles -> grants 0,1,2,3,0,1,2,3,... one per cycle.
//     Responses arrive in the same order, 16 cycles later.
//  3. req2 only, held 20 cycles -> 20 back-to-back resp_valid=4'b0100,
//     each resp_data matching its angle.
//  4. flush with 5 in flight -> req_ready=0 next cycle; 5 responses still delivered;
//     flush_done=1 the cycle after busy falls. Deassert flush -> RUN, grants resume.
//  5. reset at 8 cycles after issuing 3 requests -> zero resp_valid for the next 20 cycles;
//     rr_ptr back to 0 (first grant goes to req0 when all are valid).
//  6. STATS_EN build, 70000 req1 handshakes -> issue_cnt[1]=16'hFFFF, others 0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package cordic_pkg;

  localparam int CORDIC_LAT_DEF = 16;
  localparam int DATA_W         = 32;
  // Widest tag id needed for the largest supported requester count (8).
  localparam int TAG_ID_W       = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cordic_tag_pipe.sv
// Tag shift register following each issued angle through the core, plus busy flag.
// Latency: DEPTH cycles from i_vld/i_id to o_tail.
// Backpressure: none; advances every cycle and never stalls.
module cordic_tag_pipe
  import cordic_pkg::*;
#(
  parameter int DEPTH = 17,
  parameter int ID_W  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_vld,
  input  logic [ID_W-1:0] i_id,
  output tag_t            o_tail,
  output logic            o_busy
);

  tag_t r_pipe [DEPTH];

  // Shift every cycle; reset drops every tag so stale core data is never claimed.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0] <= '{valid: i_vld, id: TAG_ID_W'(i_id)};
      for (int s = 1; s < DEPTH; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign o_tail = r_pipe[DEPTH-1];

  // Busy while any stage still carries an in-flight tag.
  always_comb begin
    o_busy = 1'b0;
    for (int s = 0; s < DEPTH; s++) o_busy = o_busy | r_pipe[s].valid;
  end

endmodule

// File: rtl/cordic_req_scheduler.sv
// Round-robin scheduler sharing one pipelined CORDIC cosine core among NREQ requesters.
// Latency: grant -> cordic_angle next edge; matching response CORDIC_LAT cycles later, issue order.
// Backpressure: one grant per cycle via req_ready; responses cannot stall. CORDIC_SCHED_STATS_EN adds issue_cnt.
module cordic_req_scheduler
  import cordic_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int CORDIC_LAT = CORDIC_LAT_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_W-1:0]     req_angle,
  output logic [NREQ-1:0]            req_ready,
  output logic [DATA_W-1:0]          cordic_angle,
  input  logic [DATA_W-1:0]          cordic_cos,
  output logic [NREQ-1:0]            resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic [$clog2(NREQ)-1:0]    resp_id,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       busy
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]         issue_cnt
`endif
);

  localparam int ID_W = $clog2(NREQ);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic            w_issue_en;
  logic            w_gnt_vld;
  logic [ID_W-1:0] w_gnt_idx;
  logic [ID_W:0]   w_scan;
  logic            w_hs;
  tag_t            w_tail;

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping at NREQ.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_scan >= (ID_W+1)'(NREQ)) w_scan = w_scan - (ID_W+1)'(NREQ);
      if (!w_gnt_vld && req_valid[w_scan[ID_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan[ID_W-1:0];
      end
    end
  end

  // Flush FSM next state and outputs; flush in RUN blocks the grant in that same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_issue_en  = 1'b0;
    flush_done  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (flush) w_state_nxt = ST_DRAIN;
        else       w_issue_en  = 1'b1;
      end
      ST_DRAIN: begin
        if (!busy) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        flush_done = 1'b1;
        if (!flush) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_hs = w_gnt_vld & w_issue_en & ~reset;

  // One-hot ready for the granted requester; the grant only goes to a valid one.
  always_comb begin
    req_ready = '0;
    if (w_hs) req_ready[w_gnt_idx] = 1'b1;
  end

  // State, rotation pointer and core input register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_rr_ptr     <= '0;
      cordic_angle <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        cordic_angle <= req_angle[int'(w_gnt_idx)*DATA_W +: DATA_W];
        r_rr_ptr     <= (w_gnt_idx == ID_W'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
      end else begin
        cordic_angle <= '0;
      end
    end
  end

  // Stage 0 sits beside cordic_angle; CORDIC_LAT more stages line up with the core output.
  cordic_tag_pipe #(
    .DEPTH (CORDIC_LAT + 1),
    .ID_W  (ID_W)
  ) u_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .i_vld  (w_hs),
    .i_id   (w_gnt_idx),
    .o_tail (w_tail),
    .o_busy (busy)
  );

  // Route the core result to the owner recorded in the tail tag.
  always_comb begin
    resp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      resp_valid[k] = w_tail.valid && (w_tail.id == TAG_ID_W'(k));
    end
  end

  assign resp_id   = w_tail.id[ID_W-1:0];
  assign resp_data = cordic_cos;

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] r_cnt [NREQ];

  // Per-requester handshake counters, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NREQ; k++) r_cnt[k] <= '0;
    end else if (w_hs && (r_cnt[w_gnt_idx] != 16'hFFFF)) begin
      r_cnt[w_gnt_idx] <= r_cnt[w_gnt_idx] + 16'd1;
    end
  end

  // Flatten counters onto the output bus, requester k at bits [16k+15:16k].
  always_comb begin
    issue_cnt = '0;
    for (int k = 0; k < NREQ; k++) issue_cnt[16*k +: 16] = r_cnt[k];
  end
`endif

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Directed bench for cordic_req_scheduler with a stand-in fixed-latency core.
// Latency: responses expected CORDIC_LAT cycles after the cordic_angle update.
// Backpressure: none on responses; grants checked cycle by cycle.
`timescale 1ns/1ps
module tb_cordic_req_scheduler;

  localparam int NREQ = 4;
  localparam int LAT  = 16;

  logic                clock = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_angle;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         cordic_angle;
  logic [31:0]         cordic_cos;
  logic [NREQ-1:0]     resp_valid;
  logic [31:0]         resp_data;
  logic [1:0]          resp_id;
  logic                flush;
  logic                flush_done;
  logic                busy;
`ifdef CORDIC_SCHED_STATS_EN
  logic [NREQ*16-1:0]  issue_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_rr = 0;
  bit mon_en = 1'b0;

  int          exp_id   [int];
  logic [31:0] exp_data [int];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  cordic_req_scheduler #(.NREQ(NREQ), .CORDIC_LAT(LAT)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_angle    (req_angle),
    .req_ready    (req_ready),
    .cordic_angle (cordic_angle),
    .cordic_cos   (cordic_cos),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_id      (resp_id),
    .flush        (flush),
    .flush_done   (flush_done),
    .busy         (busy)
`ifdef CORDIC_SCHED_STATS_EN
    ,
    .issue_cnt    (issue_cnt)
`endif
  );

  // Stand-in core: LAT-cycle delay, result = bitwise NOT of its angle so each result is traceable.
  logic [31:0] core_q [LAT];
  always @(posedge clock) begin
    core_q[0] <= cordic_angle;
    for (int s = 1; s < LAT; s++) core_q[s] <= core_q[s-1];
  end
  assign cordic_cos = ~core_q[LAT-1];

  // Response scoreboard: each cycle either the scheduled response or silence.
  always @(negedge clock) begin
    logic [3:0] oh;
    if (mon_en) begin
      checks++;
      if (exp_id.exists(cyc)) begin
        oh = 4'(1) << exp_id[cyc];
        if (resp_valid !== oh || resp_id !== 2'(exp_id[cyc]) || resp_data !== exp_data[cyc]) begin
          errors++;
          $display("FAIL resp cyc=%0d valid=%b exp=%b id=%0d exp=%0d data=%h exp=%h",
                   cyc, resp_valid, oh, resp_id, exp_id[cyc], resp_data, exp_data[cyc]);
        end
        exp_id.delete(cyc);
        exp_data.delete(cyc);
      end else if (resp_valid !== 4'b0000) begin
        errors++;
        $display("FAIL resp_idle cyc=%0d valid=%b exp=0000", cyc, resp_valid);
      end
    end
  end

  function automatic logic [31:0] ang_of(input int i, input int seq);
    return {4'hA, 4'(i), 24'(seq)};
  endfunction

  task automatic drive(input logic [3:0] v, input int seq, input logic fl);
    @(negedge clock);
    req_valid = v;
    flush     = fl;
    for (int i = 0; i < NREQ; i++) req_angle[32*i +: 32] = ang_of(i, seq);
    #1;
  endtask

  // Record the response owed for a handshake on the coming edge.
  task automatic expect_resp(input int id, input logic [31:0] ang);
    exp_id[cyc + 1 + LAT]   = id;
    exp_data[cyc + 1 + LAT] = ~ang;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'b0000, 0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = '0; req_angle = '0; flush = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (cordic_angle !== 32'h0) begin errors++; $display("FAIL reset_angle got=%h exp=0", cordic_angle); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id got=%0d exp=0", resp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
`ifdef CORDIC_SCHED_STATS_EN
    checks++; if (issue_cnt !== '0) begin errors++; $display("FAIL reset_issue_cnt got=%h exp=0", issue_cnt); end
`endif
    reset  = 1'b0;
    exp_rr = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    drive(4'b0001, 0, 1'b0);
    req_angle[31:0] = 32'h0;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    expect_resp(0, 32'h0);
    exp_rr = 1;
    drive(4'b0000, 0, 1'b0);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_idle_ready got=%b exp=0000", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    idle(LAT + 4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin;
    logic [3:0] e;
    for (int n = 0; n < 12; n++) begin
      drive(4'b1111, n, 1'b0);
      e = 4'(1) << exp_rr;
      checks++; if (req_ready !== e) begin errors++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, req_ready, e); end
      expect_resp(exp_rr, ang_of(exp_rr, n));
      exp_rr = (exp_rr + 1) % NREQ;
    end
    idle(LAT + 4);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 20; n++) begin
      drive(4'b0100, 50 + n, 1'b0);
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_grant n=%0d got=%b exp=0100", n, req_ready); end
      if (n > 0) begin
        checks++;
        if (cordic_angle !== ang_of(2, 49 + n)) begin
          errors++; $display("FAIL b2b_angle n=%0d got=%h exp=%h", n, cordic_angle, ang_of(2, 49 + n));
        end
      end
      expect_resp(2, ang_of(2, 50 + n));
    end
    exp_rr = 3;
    idle(LAT + 4);
  endtask

  task automatic test_flush;
    int  c0;
    bit  found;
    for (int n = 0; n < 5; n++) begin
      drive(4'b0001, 100 + n, 1'b0);
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_pre_grant n=%0d got=%b exp=0001", n, req_ready); end
      expect_resp(0, ang_of(0, 100 + n));
    end
    exp_rr = 1;
    drive(4'b0001, 200, 1'b1);
    c0 = cyc;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_wins got=%b exp=0000", req_ready); end
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      drive(4'b0001, 200, 1'b1);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL drain_ready k=%0d got=%b exp=0000", k, req_ready); end
      if (busy === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found || (cyc - c0) != 17) begin
      errors++; $display("FAIL busy_fall found=%0d after=%0d exp=17", found, cyc - c0);
    end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL drain_flush_done got=%b exp=0", flush_done); end
    drive(4'b0001, 200, 1'b1);
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL done_flush_done got=%b exp=1", flush_done); end
    drive(4'b0001, 200, 1'b1);
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL done_hold got=%b exp=1", flush_done); end
    drive(4'b0001, 201, 1'b0);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL done_ready got=%b exp=0000", req_ready); end
    drive(4'b0001, 202, 1'b0);
    checks++; if (req_ready !== 4'b0001 || flush_done !== 1'b0) begin
      errors++; $display("FAIL resume ready=%b exp=0001 flush_done=%b exp=0", req_ready, flush_done);
    end
    expect_resp(0, ang_of(0, 202));
    exp_rr = 1;
    idle(LAT + 4);
  endtask

  task automatic test_reset_midflight;
    logic [3:0] g [3];
    g[0] = 4'b0010; g[1] = 4'b0100; g[2] = 4'b0010;
    // rr starts at 1 with only 1 and 2 requesting: 1, 2, then wrap back to 1 (rr ends at 2).
    for (int n = 0; n < 3; n++) begin
      drive(4'b0110, 250 + n, 1'b0);
      checks++; if (req_ready !== g[n]) begin errors++; $display("FAIL mid_grant n=%0d got=%b exp=%b", n, req_ready, g[n]); end
    end
    idle(7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    @(negedge clock);
    reset = 1'b1; req_valid = '0;
    @(negedge clock);
    reset = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after got=%b exp=0", busy); end
    idle(20);
    drive(4'b1111, 300, 1'b0);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_reset got=%b exp=0001", req_ready); end
    expect_resp(0, ang_of(0, 300));
    exp_rr = 1;
    idle(LAT + 4);
  endtask

`ifdef CORDIC_SCHED_STATS_EN
  task automatic test_stats;
    mon_en = 1'b0;
    @(negedge clock);
    reset = 1'b1; req_valid = '0;
    @(negedge clock);
    reset = 1'b0; #1;
    checks++; if (issue_cnt !== '0) begin errors++; $display("FAIL stats_clear got=%h exp=0", issue_cnt); end
    for (int n = 0; n < 70000; n++) begin
      drive(4'b0010, n, 1'b0);
      if (n == 100) begin
        checks++;
        if (issue_cnt !== {16'd0, 16'd0, 16'd100, 16'd0}) begin
          errors++; $display("FAIL stats_100 got=%h exp=%h", issue_cnt, {16'd0, 16'd0, 16'd100, 16'd0});
        end
      end
    end
    drive(4'b0000, 0, 1'b0);
    checks++;
    if (issue_cnt !== {16'd0, 16'd0, 16'hFFFF, 16'd0}) begin
      errors++; $display("FAIL stats_sat got=%h exp=%h", issue_cnt, {16'd0, 16'd0, 16'hFFFF, 16'd0});
    end
    idle(LAT + 4);
    mon_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_back_to_back;
    test_flush;
    test_reset_midflight;
`ifdef CORDIC_SCHED_STATS_EN
    test_stats;
`endif
    idle(2);
    checks++;
    if (exp_id.size() != 0) begin
      errors++; $display("FAIL resp_missing got=%0d pending exp=0", exp_id.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
